// File: rtl/ntt_pkg.sv
// ntt_pkg: shared constants, FSM state type and coefficient-mapping helpers
// for the NTT address generator.
//   LANES     - butterflies scheduled per beat
//   BANK_W    - bank-select / lane-index width
//   IDX_W     - working width for coefficient indices (covers LOGN up to 10)
//   IDX_IDENT - identity lane-select vector {7,6,5,4,3,2,1,0}
//   digit_bank(i)     - sum of 3-bit digits of i, mod 8
//   insert_zero(t, p) - t with a 0 bit inserted at position p
package ntt_pkg;

  localparam int unsigned LANES  = 8;
  localparam int unsigned BANK_W = 3;
  localparam int unsigned IDX_W  = 16;

  localparam logic [LANES*BANK_W-1:0] IDX_IDENT = 24'hFAC688;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [BANK_W-1:0] digit_bank(input logic [IDX_W-1:0] i);
    logic [BANK_W-1:0] acc;
    acc = '0;
    for (int unsigned d = 0; d < 5; d++) begin
      acc = acc + i[3*d +: 3];
    end
    acc = acc + {2'b00, i[IDX_W-1]};
    return acc;
  endfunction

  function automatic logic [IDX_W-1:0] insert_zero(input logic [IDX_W-1:0] t,
                                                   input logic [3:0]       p);
    logic [IDX_W-1:0] lo;
    lo = (IDX_W'(1) << p) - IDX_W'(1);
    return ((t & ~lo) << 1) | (t & lo);
  endfunction

endpackage

// File: rtl/ntt_lane_addr.sv
// ntt_lane_addr: combinational mapping of one butterfly lane.
// From stage s and group counter g, forms the lane's top/bottom coefficient
// indices and returns their in-bank addresses and bank numbers.
//   i_stage  - stage s (0..LOGN-1)
//   i_grp    - group counter g within the stage
//   o_addr_a - in-bank address of the top element (port A)
//   o_addr_b - in-bank address of the bottom element (port B)
//   o_bank_a - bank holding the top element
//   o_bank_b - bank holding the bottom element
module ntt_lane_addr
  import ntt_pkg::*;
#(
  parameter int unsigned LOGN = 8,
  parameter int unsigned LANE = 0,
  parameter int unsigned ADW  = LOGN - 3
) (
  input  logic [3:0]        i_stage,
  input  logic [LOGN-5:0]   i_grp,
  output logic [ADW-1:0]    o_addr_a,
  output logic [ADW-1:0]    o_addr_b,
  output logic [BANK_W-1:0] o_bank_a,
  output logic [BANK_W-1:0] o_bank_b
);

  localparam logic [2:0] K = 3'(LANE);

  logic [3:0]      w_p;
  logic [LOGN-2:0] w_t;
  logic [LOGN-1:0] w_top;
  logic [LOGN-1:0] w_bot;

  always_comb begin
    w_p = 4'(LOGN - 1) - i_stage;
    w_t = '0;
    if (w_p >= 4'd3) begin
      w_t = {i_grp, K};
    end else begin
      // Short pair distances: lane index lands in the second 3-bit digit so
      // the lanes still spread across all eight banks.
      w_t[1:0] = i_grp[1:0];
      w_t[4:2] = K;
      for (int unsigned b = 5; b < LOGN - 1; b++) begin
        w_t[b] = i_grp[b-3];
      end
    end
    w_top = LOGN'(insert_zero(IDX_W'(w_t), w_p));
    w_bot = w_top + (LOGN'(1) << w_p);
  end

  assign o_addr_a = w_top[LOGN-1:3];
  assign o_addr_b = w_bot[LOGN-1:3];
  assign o_bank_a = digit_bank(IDX_W'(w_top));
  assign o_bank_b = digit_bank(IDX_W'(w_bot));

endmodule

// File: rtl/ntt_addr_gen.sv
// ntt_addr_gen: per-beat address and bank-select generator for the
// 8-butterfly NTT datapath (port A = top elements, port B = bottom elements).
//   clk, rst_n     - clock, synchronous active-low reset
//   start          - begin a transform (honoured only when idle)
//   out_ready      - downstream accepts the current beat
//   out_valid      - beat outputs valid
//   addr_a/addr_b  - lane k in-bank address at [k*ADW +: ADW]
//   idx_a/idx_b    - bank b lane select at [3b +: 3]
//   stage          - stage of the current beat
//   last           - final beat of the transform
//   busy           - transform in progress
//   done           - one-cycle completion pulse
module ntt_addr_gen
  import ntt_pkg::*;
#(
  parameter int unsigned LOGN = 8,
  parameter int unsigned ADW  = LOGN - 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [LANES*ADW-1:0]    addr_a,
  output logic [LANES*ADW-1:0]    addr_b,
  output logic [LANES*BANK_W-1:0] idx_a,
  output logic [LANES*BANK_W-1:0] idx_b,
  output logic [3:0]              stage,
  output logic                    last,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned GW     = LOGN - 4;
  localparam logic [3:0]  S_LAST = 4'(LOGN - 1);

  state_e                  r_state;
  logic [3:0]              r_s;
  logic [GW-1:0]           r_g;
  logic                    r_valid;
  logic                    r_last;
  logic [LANES*ADW-1:0]    r_addr_a;
  logic [LANES*ADW-1:0]    r_addr_b;
  logic [LANES*BANK_W-1:0] r_idx_a;
  logic [LANES*BANK_W-1:0] r_idx_b;

  logic                    w_hs;
  logic                    w_load;
  logic [3:0]              w_s_nxt;
  logic [GW-1:0]           w_g_nxt;
  logic                    w_last_nxt;
  logic [ADW-1:0]          w_la_a [LANES];
  logic [ADW-1:0]          w_la_b [LANES];
  logic [BANK_W-1:0]       w_lb_a [LANES];
  logic [BANK_W-1:0]       w_lb_b [LANES];
  logic [LANES*ADW-1:0]    w_addr_a;
  logic [LANES*ADW-1:0]    w_addr_b;
  logic [LANES*BANK_W-1:0] w_idx_a;
  logic [LANES*BANK_W-1:0] w_idx_b;

  // The single output register stage is loaded with the beat that will be
  // presented next, so the lane mapping is driven from the next counters.
  always_comb begin
    w_hs    = r_valid & out_ready;
    w_load  = 1'b0;
    w_s_nxt = r_s;
    w_g_nxt = r_g;
    if (r_state == IDLE && start) begin
      w_load  = 1'b1;
      w_s_nxt = '0;
      w_g_nxt = '0;
    end else if (r_state == RUN && w_hs && !r_last) begin
      w_load = 1'b1;
      if (r_g == '1) begin
        w_g_nxt = '0;
        w_s_nxt = r_s + 4'd1;
      end else begin
        w_g_nxt = r_g + GW'(1);
      end
    end
    w_last_nxt = (w_s_nxt == S_LAST) && (w_g_nxt == '1);
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    ntt_lane_addr #(
      .LOGN (LOGN),
      .LANE (k),
      .ADW  (ADW)
    ) u_lane (
      .i_stage  (w_s_nxt),
      .i_grp    (w_g_nxt),
      .o_addr_a (w_la_a[k]),
      .o_addr_b (w_la_b[k]),
      .o_bank_a (w_lb_a[k]),
      .o_bank_b (w_lb_b[k])
    );
    assign w_addr_a[k*ADW +: ADW] = w_la_a[k];
    assign w_addr_b[k*ADW +: ADW] = w_la_b[k];
  end

  // Lane banks form a permutation, so scattering each lane number into the
  // slot of its bank yields idx[b] = (b - c) mod 8 directly.
  always_comb begin
    w_idx_a = '0;
    w_idx_b = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      w_idx_a[BANK_W*w_lb_a[k] +: BANK_W] = BANK_W'(k);
      w_idx_b[BANK_W*w_lb_b[k] +: BANK_W] = BANK_W'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_s      <= '0;
      r_g      <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_idx_a  <= IDX_IDENT;
      r_idx_b  <= IDX_IDENT;
    end else begin
      if (w_load) begin
        r_s      <= w_s_nxt;
        r_g      <= w_g_nxt;
        r_addr_a <= w_addr_a;
        r_addr_b <= w_addr_b;
        r_idx_a  <= w_idx_a;
        r_idx_b  <= w_idx_b;
        r_last   <= w_last_nxt;
        r_valid  <= 1'b1;
      end
      case (r_state)
        IDLE: if (start) r_state <= RUN;
        RUN: begin
          if (w_hs && r_last) begin
            r_state <= DONE;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_valid;
  assign addr_a    = r_addr_a;
  assign addr_b    = r_addr_b;
  assign idx_a     = r_idx_a;
  assign idx_b     = r_idx_b;
  assign stage     = r_s;
  assign last      = r_last;
  assign busy      = (r_state == RUN);
  assign done      = (r_state == DONE);

endmodule

// File: tb/tb_ntt_addr_gen.sv
// tb_ntt_addr_gen: self-checking bench for ntt_addr_gen at LOGN=8 (N=256).
// A beat-level model derives every beat's addresses and selects from the
// coefficient mapping; a scoreboard rebuilds coefficients from DUT outputs
// and checks per-stage coverage.
module tb_ntt_addr_gen;

  localparam int LOGN   = 8;
  localparam int ADW    = 5;
  localparam int BEATS  = 128;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        out_ready;
  logic        out_valid;
  logic [39:0] addr_a;
  logic [39:0] addr_b;
  logic [23:0] idx_a;
  logic [23:0] idx_b;
  logic [3:0]  stage;
  logic        last;
  logic        busy;
  logic        done;

  ntt_addr_gen #(.LOGN(LOGN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .idx_a     (idx_a),
    .idx_b     (idx_b),
    .stage     (stage),
    .last      (last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int m_st     = M_IDLE;
  int exp_beat = 0;
  bit m_armed  = 1'b0;
  bit m_fresh  = 1'b0;
  int done_cnt = 0;
  int dut_beats = 0;
  int last_cnt = 0;
  bit stall_prev = 1'b0;
  logic [39:0] sv_a, sv_b;
  logic [23:0] sv_ia, sv_ib;
  logic [3:0]  sv_st;
  int cov [256];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int digsum(input int v);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) s += (v >> (3*i)) & 7;
    return s % 8;
  endfunction

  // Expected outputs of beat (s, g) straight from the schedule rules.
  function automatic void model_beat(input int s, input int g,
                                     output logic [39:0] ea, output logic [39:0] eb,
                                     output logic [23:0] ia, output logic [23:0] ib);
    int p, d, t, j, ca, cb;
    p = LOGN - 1 - s;
    d = 1 << p;
    ea = '0; eb = '0; ia = '0; ib = '0; ca = 0; cb = 0;
    for (int k = 0; k < 8; k++) begin
      if (p >= 3) t = g*8 + k;
      else        t = (g % 4) + k*4 + (g / 4)*32;
      j = (t / d) * (2*d) + (t % d);
      ea[k*ADW +: ADW] = 5'(j / 8);
      eb[k*ADW +: ADW] = 5'((j + d) / 8);
      if (k == 0) begin
        ca = digsum(j);
        cb = digsum(j + d);
      end
    end
    for (int b = 0; b < 8; b++) begin
      ia[b*3 +: 3] = 3'((b - ca + 8) % 8);
      ib[b*3 +: 3] = 3'((b - cb + 8) % 8);
    end
  endfunction

  // Rebuild each lane's coefficient from its address and selected bank.
  task automatic score_port(input string nm, input logic [39:0] ad, input logic [23:0] ix);
    int cnt, bank, a, i;
    for (int k = 0; k < 8; k++) begin
      cnt = 0; bank = 0;
      for (int b = 0; b < 8; b++) begin
        if (int'(ix[b*3 +: 3]) == k) begin
          cnt++;
          bank = b;
        end
      end
      chk({nm, "_bank_once"}, cnt, 1);
      a = int'(ad[k*ADW +: ADW]);
      i = a*8 + ((bank - digsum(a) + 8) % 8);
      cov[i]++;
    end
  endtask

  always @(negedge clk) begin : cmp
    logic [39:0] ea, eb;
    logic [23:0] ia, ib;
    int s, g, nbad;
    if (m_armed) begin
      case (m_st)
        M_RUN: begin
          s = exp_beat / 16;
          g = exp_beat % 16;
          model_beat(s, g, ea, eb, ia, ib);
          chk("out_valid", out_valid, 1);
          chk("busy", busy, 1);
          chk("done_run", done, 0);
          chk("addr_a", addr_a, ea);
          chk("addr_b", addr_b, eb);
          chk("idx_a", idx_a, ia);
          chk("idx_b", idx_b, ib);
          chk("stage", stage, 4'(s));
          chk("last", last, exp_beat == BEATS - 1);
          if (exp_beat == 0) begin
            chk("pin_s0_addr_a", addr_a, 40'd0);
            chk("pin_s0_addr_b", addr_b, {8{5'd16}});
            chk("pin_s0_idx_a", idx_a, 24'hFAC688);
            chk("pin_s0_idx_b", idx_b, 24'hB1A23E);
          end
          if (exp_beat == 112) begin
            chk("pin_s7_addr_a", addr_a, {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0});
            chk("pin_s7_addr_b", addr_b, {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0});
            chk("pin_s7_idx_a", idx_a, 24'hFAC688);
            chk("pin_s7_idx_b", idx_b, 24'hD63447);
          end
          if (stall_prev) begin
            chk("stall_addr_a", addr_a, sv_a);
            chk("stall_addr_b", addr_b, sv_b);
            chk("stall_idx_a", idx_a, sv_ia);
            chk("stall_idx_b", idx_b, sv_ib);
            chk("stall_stage", stage, sv_st);
          end
          stall_prev = !out_ready;
          sv_a = addr_a; sv_b = addr_b; sv_ia = idx_a; sv_ib = idx_b; sv_st = stage;
          if (out_ready) begin
            score_port("port_a", addr_a, idx_a);
            score_port("port_b", addr_b, idx_b);
            if (out_valid) dut_beats++;
            if (last) last_cnt++;
            if (g == 15) begin
              nbad = 0;
              for (int i = 0; i < 256; i++) begin
                if (cov[i] != 1) nbad++;
                cov[i] = 0;
              end
              chk("stage_coverage", nbad, 0);
            end
            if (exp_beat == BEATS - 1) begin
              chk("beat_count", dut_beats, BEATS);
              chk("last_count", last_cnt, 1);
              m_st = M_DONE;
            end
            exp_beat++;
          end
        end
        M_DONE: begin
          chk("done_pulse", done, 1);
          chk("done_valid", out_valid, 0);
          chk("done_busy", busy, 0);
          chk("done_last", last, 0);
          done_cnt++;
          m_st = M_IDLE;
        end
        default: begin
          chk("idle_valid", out_valid, 0);
          chk("idle_busy", busy, 0);
          chk("idle_done", done, 0);
          chk("idle_last", last, 0);
          if (m_fresh) begin
            chk("rst_addr_a", addr_a, 40'd0);
            chk("rst_addr_b", addr_b, 40'd0);
            chk("rst_idx_a", idx_a, 24'hFAC688);
            chk("rst_idx_b", idx_b, 24'hFAC688);
            chk("rst_stage", stage, 4'd0);
          end
          if (start) begin
            m_st = M_RUN;
            exp_beat = 0;
            m_fresh = 1'b0;
            dut_beats = 0;
            last_cnt = 0;
            stall_prev = 1'b0;
            for (int i = 0; i < 256; i++) cov[i] = 0;
          end
        end
      endcase
    end
    if (!rst_n) begin
      m_armed = 1'b1;
      m_st = M_IDLE;
      m_fresh = 1'b1;
      exp_beat = 0;
      stall_prev = 1'b0;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : drive
    int stall_left;
    bit pulsed;
    int cyc;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;

    // Run 1: start ignored at beat 40, 5-cycle stall at beat 52 (stage 3).
    stall_left = 5; pulsed = 1'b0; cyc = 0;
    while (done_cnt < 1 && cyc < 600) begin
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
      out_ready = 1'b1;
      if (m_st == M_RUN && exp_beat == 40 && !pulsed) begin
        start = 1'b1;
        pulsed = 1'b1;
      end
      if (m_st == M_RUN && exp_beat == 52 && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end
    end
    if (done_cnt < 1) chk("run1_timeout", 0, 1);
    start = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);

    // Run 2: reset asserted at beat 70.
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (!(m_st == M_RUN && exp_beat == 70) && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!(m_st == M_RUN && exp_beat == 70)) chk("run2_timeout", 0, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Run 3: restart after reset with intermittent ready; start during DONE.
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (done_cnt < 2 && cyc < 800) begin
      @(posedge clk);
      #1;
      cyc++;
      out_ready = (cyc % 3 != 0);
      start = (m_st == M_DONE);
    end
    if (done_cnt < 2) chk("run3_timeout", 0, 1);
    start = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
